i2s_dac_multi: RTL and testbench

//  Parametrised multi-channel I2S/left-justified audio DAC serialiser for the board audio codecs.

---
 rtl/i2s_dac_multi.sv | 163 ++++++++++++++++
 tb/tb_i2s_dac_multi.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_multi.sv
// Multi-lane I2S / left-justified DAC serialiser with a frame FIFO in front.
// NCH stereo lanes share one BCLK/DACLRC pair; each frame is 64 slots of 2*DIV clocks.
module i2s_dac_multi #(
  parameter int NCH   = 2,
  parameter int SW    = 16,
  parameter int DIV   = 4,
  parameter int DEPTH = 8,
  parameter int I2S   = 1
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      EN,
  input  logic                      WR_VALID,
  input  logic [NCH*2*SW-1:0]       WR_DATA,
  output logic                      WR_READY,
  output logic [$clog2(DEPTH):0]    FIFO_LEVEL,
  output logic                      UNDERRUN,
  input  logic                      UNDER_CLR,
  output logic                      BCLK,
  output logic                      DACLRC,
  output logic [NCH-1:0]            DACDAT
);

  localparam int FW = NCH * 2 * SW;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic            under_q;
  logic [DW-1:0]   div_cnt;
  logic [5:0]      bit_cnt;
  logic            bclk_q, lrc_q;
  logic [NCH-1:0]  lj_q, dly_q;
  logic [FW-1:0]   frame_q;

  logic            fifo_empty, push, pop, load, tick, fall, entry;
  logic [5:0]      next_slot;
  logic [FW-1:0]   next_frame, lane_sh;
  logic [NCH-1:0]  lj_next;

  // Left-justified bit of one lane for slot k; bits past SW shift out as zero.
  function automatic logic lj_bit(input logic [2*SW-1:0] lane, input logic [5:0] k);
    logic [SW-1:0] ch;
    ch = k[5] ? lane[2*SW-1:SW] : lane[SW-1:0];
    ch = ch << k[4:0];
    return ch[SW-1];
  endfunction

  assign fifo_empty = (level == '0);
  assign WR_READY   = (level != LW'(DEPTH));
  assign push       = WR_VALID & WR_READY;
  assign tick       = (div_cnt == DIV_LAST);
  assign fall       = tick & bclk_q;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    entry   = 1'b0;
    case (state_q)
      IDLE: if (EN) begin
        state_d = RUN;
        load    = 1'b1;
        entry   = 1'b1;
      end
      RUN: begin
        if (!EN)                           state_d = IDLE;
        else if (fall && bit_cnt == 6'd63) load    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop        = load & ~fifo_empty;
  assign next_frame = load ? (fifo_empty ? '0 : mem[rd_ptr]) : frame_q;
  assign next_slot  = entry ? 6'd0 : bit_cnt + 6'd1;

  always_comb begin
    lj_next = '0;
    lane_sh = '0;
    for (int n = 0; n < NCH; n++) begin
      lane_sh    = next_frame >> (n * 2 * SW);
      lj_next[n] = lj_bit(lane_sh[2*SW-1:0], next_slot);
    end
  end

  // NOTE: frame storage has no reset; the level counter alone decides which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= WR_DATA;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      under_q <= 1'b0;
      frame_q <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk_q  <= 1'b0;
      lrc_q   <= 1'b0;
      lj_q    <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= next_frame;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // A set on an empty load takes priority over a clear in the same cycle.
      if (load && fifo_empty) under_q <= 1'b1;
      else if (UNDER_CLR)     under_q <= 1'b0;

      if (state_d == IDLE) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        bclk_q  <= 1'b0;
        lrc_q   <= 1'b0;
        lj_q    <= '0;
        dly_q   <= '0;
      end else if (entry) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        bclk_q  <= 1'b0;
        lrc_q   <= 1'b0;
        lj_q    <= lj_next;
        dly_q   <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        bclk_q  <= ~bclk_q;
        if (bclk_q) begin
          bit_cnt <= next_slot;
          lrc_q   <= next_slot[5];
          lj_q    <= lj_next;
          dly_q   <= lj_q;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign FIFO_LEVEL = level;
  assign UNDERRUN   = under_q;
  assign BCLK       = bclk_q;
  assign DACLRC     = lrc_q;
  assign DACDAT     = (I2S != 0) ? dly_q : lj_q;

endmodule

// File: tb/tb_i2s_dac_multi.sv
// Bench for i2s_dac_multi: one left-justified and one I2S instance on shared stimulus,
// checked every cycle against a slot/frame-level model plus hand-computed spot values.
module tb_i2s_dac_multi;

  localparam int NCH = 2, SW = 16, DIV = 2, DEPTH = 8;
  localparam int SLOT_CLK  = 2 * DIV;
  localparam int FRAME_CLK = 64 * SLOT_CLK;

  logic        clk = 1'b0;
  logic        rst_n, en, wr_valid, under_clr;
  logic [63:0] wr_data;

  logic        lj_ready, lj_under, lj_bclk, lj_lrc;
  logic [3:0]  lj_level;
  logic [1:0]  lj_dat;
  logic        i2_ready, i2_under, i2_bclk, i2_lrc;
  logic [3:0]  i2_level;
  logic [1:0]  i2_dat;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  i2s_dac_multi #(.NCH(NCH), .SW(SW), .DIV(DIV), .DEPTH(DEPTH), .I2S(0)) u_lj (
    .CLK(clk), .RESET_N(rst_n), .EN(en), .WR_VALID(wr_valid), .WR_DATA(wr_data),
    .WR_READY(lj_ready), .FIFO_LEVEL(lj_level), .UNDERRUN(lj_under), .UNDER_CLR(under_clr),
    .BCLK(lj_bclk), .DACLRC(lj_lrc), .DACDAT(lj_dat)
  );

  i2s_dac_multi #(.NCH(NCH), .SW(SW), .DIV(DIV), .DEPTH(DEPTH), .I2S(1)) u_i2s (
    .CLK(clk), .RESET_N(rst_n), .EN(en), .WR_VALID(wr_valid), .WR_DATA(wr_data),
    .WR_READY(i2_ready), .FIFO_LEVEL(i2_level), .UNDERRUN(i2_under), .UNDER_CLR(under_clr),
    .BCLK(i2_bclk), .DACLRC(i2_lrc), .DACDAT(i2_dat)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [15:0] v, input int i);
    logic [15:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Serial bit for lane n, slot k: MSB-first sample, zero padding after SW bits.
  function automatic logic exp_bit(input logic [63:0] f, input int n, input int k);
    logic [63:0] s;
    int p;
    s = f >> (n * 32 + ((k >= 32) ? 16 : 0));
    p = k % 32;
    return (p < SW) ? bit_of(s[15:0], SW - 1 - p) : 1'b0;
  endfunction

  // Model: a frame queue, a run flag and clocks elapsed since the run began.
  logic [63:0] q[$];
  bit          m_run, m_under, m_load, m_push;
  int          m_t;
  logic [63:0] m_frame, m_prev;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_run = 0; m_under = 0; m_t = 0; m_frame = '0; m_prev = '0;
    end else begin
      m_load = 0;
      m_push = wr_valid && (q.size() < DEPTH);
      if (!en) begin
        m_run = 0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1; m_t = 0; m_load = 1;
      end else begin
        m_t++;
        if (m_t % FRAME_CLK == 0) m_load = 1;
      end
      if (m_load) begin
        m_prev = m_frame;
        if (q.size() > 0) m_frame = q.pop_front();
        else begin
          m_frame = '0;
          m_under = 1;
        end
      end else if (under_clr) m_under = 0;
      if (m_push) q.push_back(wr_data);
    end
  end

  int         c_s, c_k;
  logic       e_bclk, e_lrc;
  logic [1:0] e_lj, e_i2;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_bclk = 0; e_lrc = 0; e_lj = '0; e_i2 = '0;
      if (m_run) begin
        c_s    = m_t / SLOT_CLK;
        c_k    = c_s % 64;
        e_bclk = (m_t % SLOT_CLK) >= DIV;
        e_lrc  = c_k >= 32;
        for (int n = 0; n < NCH; n++) begin
          e_lj[n] = exp_bit(m_frame, n, c_k);
          if (c_s == 0)      e_i2[n] = 1'b0;
          else if (c_k == 0) e_i2[n] = exp_bit(m_prev, n, 63);
          else               e_i2[n] = exp_bit(m_frame, n, c_k - 1);
        end
      end
      check("lj_bclk",   lj_bclk, e_bclk);
      check("lj_lrc",    lj_lrc,  e_lrc);
      check("lj_dat",    lj_dat,  e_lj);
      check("i2s_bclk",  i2_bclk, e_bclk);
      check("i2s_lrc",   i2_lrc,  e_lrc);
      check("i2s_dat",   i2_dat,  e_i2);
      check("level",     lj_level, q.size());
      check("i2s_level", i2_level, q.size());
      check("ready",     lj_ready, q.size() != DEPTH);
      check("underrun",  lj_under, m_under);
      check("i2s_under", i2_under, m_under);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [15:0] pat;
  int          s;

  initial begin
    rst_n = 0; en = 0; wr_valid = 0; under_clr = 0; wr_data = '0;
    pat = 16'b1010_0101_1111_0000;
    cycles(3);
    cmp_en = 1;
    check("rst_level", lj_level, 0);
    check("rst_ready", lj_ready, 1);
    rst_n = 1;

    // One frame queued, run three frames: data pattern, LRC edge, underrun and clear.
    wr_data = {16'hFFFF, 16'h8001, 16'h0F0F, 16'hA5F0};
    wr_valid = 1;
    cycles(1);
    wr_valid = 0;
    check("one_queued", lj_level, 1);
    en = 1;
    cycles(1);
    for (int t = 0; t < 600; t++) begin
      s = t / SLOT_CLK;
      if (t % SLOT_CLK == 1 && s < 32) begin
        check("lj_lane0_slot", lj_dat[0], (s < 16) ? bit_of(pat, 15 - s) : 1'b0);
        check("i2s_lane0_slot", i2_dat[0],
              (s >= 1 && s <= 16) ? bit_of(pat, 16 - s) : 1'b0);
      end
      if (t % SLOT_CLK == 1 && s >= 32 && s < 48) check("lj_lane1_right", lj_dat[1], 1);
      if (t == 127) begin
        check("lrc_before", lj_lrc, 0);
        check("i2s_lrc_before", i2_lrc, 0);
      end
      if (t == 128) begin
        check("lrc_rise", lj_lrc, 1);
        check("i2s_lrc_rise", i2_lrc, 1);
      end
      if (t == 255) check("under_before", lj_under, 0);
      if (t == 256) begin
        check("under_set", lj_under, 1);
        check("under_dat", lj_dat, 0);
      end
      if (t == 300) under_clr = 1;
      if (t == 301) begin
        under_clr = 0;
        check("under_clr", lj_under, 0);
      end
      if (t == 511) check("under_held", lj_under, 0);
      if (t == 512) check("under_reset", lj_under, 1);
      cycles(1);
    end
    en = 0;
    cycles(2);
    check("idle_bclk", lj_bclk, 0);

    // Abandon a frame at slot 20 and restart with a fresh pop.
    wr_valid = 1;
    wr_data  = 64'h1234_5678_9ABC_DEF0;
    cycles(1);
    wr_data  = {16'h5555, 16'h0001, 16'hAAAA, 16'h8000};
    cycles(1);
    wr_valid = 0;
    en = 1;
    cycles(1 + 20 * SLOT_CLK);
    en = 0;
    cycles(1);
    check("stop_bclk", lj_bclk, 0);
    check("stop_lrc", lj_lrc, 0);
    cycles(3);
    en = 1;
    cycles(1);
    check("restart_level", lj_level, 0);
    check("restart_bclk", lj_bclk, 0);
    check("restart_lj_dat", lj_dat, 2'b01);
    check("restart_i2s_dat", i2_dat, 2'b00);
    cycles(40);
    en = 0;
    cycles(2);

    // Fill past full, then pop and write in the same cycle while full.
    wr_valid = 1;
    for (int i = 0; i < 9; i++) begin
      wr_data = {$urandom, $urandom};
      if (i == 8) begin
        check("full_level", lj_level, 8);
        check("full_ready", lj_ready, 0);
      end
      cycles(1);
    end
    check("ninth_refused", lj_level, 8);
    wr_data = 64'hDEAD_BEEF_CAFE_F00D;
    en = 1;
    cycles(1);
    wr_valid = 0;
    check("pop_write_full", lj_level, 7);
    check("pop_write_ready", lj_ready, 1);
    cycles(100);
    en = 0;

    // Reset mid-frame with three frames still queued.
    rst_n = 0;
    cycles(1);
    rst_n = 1;
    wr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wr_data = {$urandom, $urandom};
      cycles(1);
    end
    wr_valid = 0;
    en = 1;
    cycles(100);
    check("pre_reset_level", lj_level, 3);
    rst_n = 0;
    en = 0;
    cycles(1);
    rst_n = 1;
    check("mid_rst_level", lj_level, 0);
    check("mid_rst_ready", lj_ready, 1);
    check("mid_rst_bclk", lj_bclk, 0);
    check("mid_rst_lrc", i2_lrc, 0);
    check("mid_rst_dat", {lj_dat, i2_dat}, 0);
    cycles(5);

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
